mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 15, maximum wait for mem_ack in cycles.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 cpu_req  input  1  CPU access request; held until cpu_ready.
REQ-005 cpu_we, cpu_addr, cpu_wdata  input  1/ADDR_W/DATA_W  CPU write-enable, address and write data.
REQ-006 cpu_ready  output  1  one-cycle completion pulse to the CPU; drives the control FSM's MIO_ready.
REQ-007 dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_W/DATA_W  second requester (display/DMA), same rules as the CPU port.
REQ-008 dma_ready  output  1  one-cycle completion pulse to the DMA port.
REQ-009 rdata  output  DATA_W  read data; valid while either ready is high.
REQ-010 err  output  1  high with the ready pulse when the access timed out.
REQ-011 mem_req, mem_we, mem_addr, mem_wdata  output  1/1/ADDR_W/DATA_W  shared memory port.
REQ-012 mem_rdata, mem_ack  input  DATA_W/1  memory read data; memory completion, valid only while mem_req is high.
REQ-013 state_out  output  2  current FSM state, for debug.

Function
REQ-014 The FSM SHALL have 4 states: IDLE=0, CPU_ACC=1, DMA_ACC=2, RESP=3.
REQ-015 In IDLE with only one request high, that request SHALL be granted.
REQ-016 In IDLE with both requests high, the port not in last_grant SHALL be granted (round-robin).
REQ-017 last_grant SHALL reset to DMA, so the CPU wins the first tie.
REQ-018 On a grant, the arbiter SHALL latch the winner's we/addr/wdata, set owner and last_grant, and move to CPU_ACC or DMA_ACC.
REQ-019 mem_req SHALL be registered: high in every ACC cycle, low in IDLE and RESP.
REQ-020 mem_we/mem_addr/mem_wdata SHALL come only from the latched copies; requester inputs changing during ACC SHALL have no effect.
REQ-021 mem_ack SHALL be sampled only in ACC states; mem_ack in IDLE or RESP SHALL be ignored.
REQ-022 On mem_ack in ACC: rdata <= mem_rdata (writes also capture it), err <= 0, next state RESP.
REQ-023 The wait counter SHALL clear on grant and increment each ACC cycle without ack.
REQ-024 When the counter reaches TIMEOUT-1 without ack: mem_req drops, rdata <= 0, err <= 1, next state RESP.
REQ-025 RESP SHALL last exactly one cycle: the owner's ready=1 and the other ready=0, then IDLE.
REQ-026 Requests SHALL NOT be sampled in RESP.
REQ-027 Latency: request in IDLE at cycle N, mem_req at N+1, ack at N+k (k>=1), ready at N+k+1. Minimum 2 cycles; back-to-back grants 3 cycles apart.
REQ-028 A requester that holds req high in the IDLE cycle after its ready SHALL be treated as making a new request.
REQ-029 cpu_ready and dma_ready SHALL never be high together; neither SHALL be high outside RESP.

Reset
REQ-030 While reset=0, outputs SHALL be: state IDLE; mem_req, mem_we, cpu_ready, dma_ready, err = 0; mem_addr, mem_wdata, rdata = 0; counter = 0.
REQ-031 Reset asserted mid-access SHALL drop mem_req immediately (asynchronously) and produce no ready pulse.
REQ-032 After reset release, the first grant SHALL occur at the first rising edge with reset=1 and a request high.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state encodings, the owner encoding (CPU=0, DMA=1) and the default TIMEOUT.
REQ-034 The wait counter SHALL be one sub-module, mem_arb_timer (clear, enable, expired), with the FSM in mem_arbiter.

Verification
REQ-035 CPU read alone: cpu_addr=0x10, memory acks 2 cycles after mem_req with 0x12345678 -> mem_req high 2 cycles, cpu_ready one cycle, rdata=0x12345678, err=0, total 4 cycles.
REQ-036 Tie from reset, both requesters held continuously -> grants in order CPU, DMA, CPU, DMA; each ready pulses once per grant; never both readies high.
REQ-037 DMA write, dma_wdata changed to 0xFFFFFFFF mid-access after grant with 0xA5A5A5A5 -> mem_wdata stays 0xA5A5A5A5 until ack.
REQ-038 CPU access, no mem_ack, TIMEOUT=15 -> mem_req high exactly 15 cycles, then cpu_ready=1, err=1, rdata=0.
REQ-039 reset driven to 0 in the 2nd ACC cycle -> mem_req falls before the next edge; no ready pulse; state_out=0.
REQ-040 Spurious mem_ack in IDLE and in RESP -> no state change and no extra ready pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, port owner
// and the default access timeout.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_ACC = 2'd1,
    ST_DMA_ACC = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU, DMA and shared-memory handshakes around the arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req, cpu_we, cpu_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              dma_req, dma_we, dma_ready;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        state_out;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata, mem_ack,
    output cpu_ready, dma_ready, rdata, err,
    output mem_req, mem_we, mem_addr, mem_wdata, state_out
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata, mem_ack,
    input  cpu_ready, dma_ready, rdata, err,
    input  mem_req, mem_we, mem_addr, mem_wdata, state_out
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Wait counter for one memory access; expired flags the last allowed cycle.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between a CPU and a DMA
// requester, with per-access timeout and a one-cycle ready pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);
  state_e            state_q, state_d;
  owner_e            owner_q, owner_d, last_q, last_d;
  logic              we_q, we_d, err_q, err_d, mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              grant, gnt_dma, tmr_en, expired;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (grant),
    .enable (tmr_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;

  // Next state plus the datapath captures that move with each transition.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_req_d = mem_req_q;
    grant     = 1'b0;
    gnt_dma   = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.cpu_req || bus.dma_req) begin
        grant     = 1'b1;
        gnt_dma   = bus.dma_req && (!bus.cpu_req || last_q == OWN_CPU);
        owner_d   = gnt_dma ? OWN_DMA : OWN_CPU;
        last_d    = owner_d;
        we_d      = gnt_dma ? bus.dma_we    : bus.cpu_we;
        addr_d    = gnt_dma ? bus.dma_addr  : bus.cpu_addr;
        wdata_d   = gnt_dma ? bus.dma_wdata : bus.cpu_wdata;
        mem_req_d = 1'b1;
        state_d   = gnt_dma ? ST_DMA_ACC : ST_CPU_ACC;
      end
      ST_CPU_ACC, ST_DMA_ACC: begin
        tmr_en = !bus.mem_ack;
        if (bus.mem_ack) begin
          rdata_d   = bus.mem_rdata;
          err_d     = 1'b0;
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end else if (expired) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner_q   <= OWN_CPU;
      last_q    <= OWN_DMA;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      mem_req_q <= mem_req_d;
    end

  always_comb begin
    bus.cpu_ready = (state_q == ST_RESP) && (owner_q == OWN_CPU);
    bus.dma_ready = (state_q == ST_RESP) && (owner_q == OWN_DMA);
    bus.rdata     = rdata_q;
    bus.err       = err_q;
    bus.mem_req   = mem_req_q;
    bus.mem_we    = we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.state_out = state_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected responses are queued at issue time
// and popped by a monitor on every ready pulse.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit          dma;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0, n_fail = 0;
  int          ack_lat = 0;
  logic [31:0] rd_base = '0;
  bit          spur_ack = 0;
  int          run_len = 0, last_len = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push(input bit dma, input logic [31:0] rd, input bit e);
    exp_t x;
    x.dma = dma; x.rdata = rd; x.err = e;
    sb.push_back(x);
  endtask

  task automatic wait_ready(input bit dma, input int maxc, input string nm, output int cyc);
    bit seen = 0;
    cyc = 0;
    while (!seen && cyc < maxc) begin
      @(negedge clk);
      cyc++;
      seen = dma ? bus.dma_ready : bus.cpu_ready;
    end
    chk({nm, "_ready_seen"}, 64'(seen), 64'd1);
  endtask

  // Memory model: acks in the ack_lat-th mem_req cycle (0 = never).
  initial begin
    int acc_cyc = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) acc_cyc++;
      else                      acc_cyc = 0;
      bus.mem_ack   = (bus.mem_req === 1'b1 && ack_lat != 0 && acc_cyc == ack_lat) || spur_ack;
      bus.mem_rdata = rd_base + bus.mem_addr;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (reset !== 1'b1) run_len = 0;
    else begin
      if (bus.cpu_ready || bus.dma_ready) begin
        chk("ready_exclusive", 64'(bus.cpu_ready & bus.dma_ready), 64'd0);
        chk("ready_in_resp", 64'(bus.state_out), 64'd3);
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_ready: cpu=%0b dma=%0b with no queued response",
                   bus.cpu_ready, bus.dma_ready);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_owner", 64'(bus.dma_ready), 64'(mon_e.dma));
          chk("resp_rdata", 64'(bus.rdata), 64'(mon_e.rdata));
          chk("resp_err", 64'(bus.err), 64'(mon_e.err));
        end
      end
      if (bus.mem_req === 1'b1) run_len++;
      else if (run_len != 0) begin
        last_len = run_len;
        run_len  = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, cnt, lastc;
    reset = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(bus.state_out), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_readies", 64'({bus.cpu_ready, bus.dma_ready}), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_addr_wdata_rdata", {bus.mem_addr, bus.mem_wdata ^ bus.rdata}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // CPU read alone, ack in 2nd mem_req cycle.
    ack_lat = 2; rd_base = 32'h1234_5668;
    push(0, 32'h1234_5678, 0);
    bus.cpu_addr = 32'h10; bus.cpu_we = 0; bus.cpu_req = 1;
    @(negedge clk);
    chk("t1_mem_addr", 64'(bus.mem_addr), 64'h10);
    chk("t1_mem_we", 64'(bus.mem_we), 64'd0);
    wait_ready(0, 10, "t1", cyc);
    bus.cpu_req = 0;
    chk("t1_latency", 64'(cyc), 64'd2);
    @(negedge clk);
    chk("t1_mem_req_len", 64'(last_len), 64'd2);

    // Tie from reset, both held: CPU, DMA, CPU, DMA.
    reset = 1'b0;
    @(negedge clk);
    ack_lat = 1; rd_base = '0;
    bus.cpu_addr = 32'h100; bus.dma_addr = 32'h200;
    push(0, 32'h100, 0); push(1, 32'h200, 0); push(0, 32'h100, 0); push(1, 32'h200, 0);
    reset = 1'b1; bus.cpu_req = 1; bus.dma_req = 1;
    cnt = 0; lastc = 0;
    for (int i = 1; i <= 20 && cnt < 4; i++) begin
      @(negedge clk);
      if (bus.cpu_ready || bus.dma_ready) begin cnt++; lastc = i; end
    end
    bus.cpu_req = 0; bus.dma_req = 0;
    chk("t2_ready_count", 64'(cnt), 64'd4);
    chk("t2_last_ready_cycle", 64'(lastc), 64'd11);
    @(negedge clk);

    // DMA write, wdata/addr changed mid-access.
    ack_lat = 4;
    push(1, 32'h40, 0);
    bus.dma_we = 1; bus.dma_addr = 32'h40; bus.dma_wdata = 32'hA5A5_A5A5; bus.dma_req = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin bus.dma_wdata = 32'hFFFF_FFFF; bus.dma_addr = 32'hFFC; end
      chk("t3_mem_wdata_held", 64'(bus.mem_wdata), 64'hA5A5_A5A5);
      chk("t3_mem_addr_held", {31'd0, bus.mem_we, bus.mem_addr}, 64'h1_0000_0040);
    end
    wait_ready(1, 3, "t3", cyc);
    bus.dma_req = 0; bus.dma_we = 0;
    chk("t3_latency", 64'(cyc), 64'd1);
    @(negedge clk);

    // Timeout: no ack ever.
    ack_lat = 0;
    push(0, 32'h0, 1);
    bus.cpu_addr = 32'h20; bus.cpu_req = 1;
    wait_ready(0, 30, "t4", cyc);
    bus.cpu_req = 0;
    chk("t4_latency", 64'(cyc), 64'd16);
    @(negedge clk);
    chk("t4_mem_req_len", 64'(last_len), 64'd15);

    // Spurious ack in RESP and following IDLE.
    ack_lat = 1;
    push(0, 32'h30, 0);
    bus.cpu_addr = 32'h30; bus.cpu_req = 1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.cpu_req = 0; spur_ack = 1;
    @(negedge clk);
    chk("t5_resp_ready", 64'(bus.cpu_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_idle_state", 64'(bus.state_out), 64'd0);
      chk("t5_no_ready", 64'({bus.cpu_ready, bus.dma_ready, bus.mem_req}), 64'd0);
    end
    @(posedge clk); #1;
    spur_ack = 0;
    @(negedge clk);

    // Reset in 2nd ACC cycle.
    ack_lat = 0;
    bus.cpu_addr = 32'h44; bus.cpu_req = 1;
    @(negedge clk);
    chk("t6_acc1_mem_req", 64'(bus.mem_req), 64'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t6_async_mem_req", 64'(bus.mem_req), 64'd0);
    chk("t6_async_state", 64'(bus.state_out), 64'd0);
    chk("t6_no_ready", 64'({bus.cpu_ready, bus.dma_ready}), 64'd0);
    bus.cpu_req = 0;
    repeat (2) @(negedge clk);

    // First edge after release grants; held req after ready is a new request.
    ack_lat = 1; rd_base = 32'h1000;
    bus.cpu_addr = 32'h50;
    push(0, 32'h1050, 0); push(0, 32'h1050, 0);
    reset = 1'b1; bus.cpu_req = 1;
    @(negedge clk);
    chk("t7_first_grant", {62'd0, bus.mem_req, 1'b0} | 64'(bus.state_out), 64'd3);
    wait_ready(0, 5, "t7a", cyc);
    chk("t7a_latency", 64'(cyc), 64'd1);
    wait_ready(0, 6, "t7b", cyc);
    bus.cpu_req = 0;
    chk("t7b_latency", 64'(cyc), 64'd3);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
